// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_e   : scan FSM encoding (idle, blanking window, digit drive)
//   SEG_BLANK : active-low pattern with every segment dark
//   hex_glyph : nibble -> active-low {g,f,e,d,c,b,a} glyph
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; A-F use A b C d E F.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the value producer, the scan controller and the display pins.
//   en, value, load, dp_mask, lz_blank : producer -> controller
//   seg, dp, an, frame                 : controller -> pins / producer
// Handshake: there is no back-pressure. load is a single-cycle strobe; the
// controller captures value on every clock edge where load=1, and the most
// recent strobe always wins. dp_mask and lz_blank are sampled live.
// The master modport is the producer side, slave is the controller.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic                  load;
    logic [DIGITS-1:0]     dp_mask;
    logic                  lz_blank;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame;

    modport master (
        output en, value, load, dp_mask, lz_blank,
        input  seg, dp, an, frame
    );

    modport slave (
        input  en, value, load, dp_mask, lz_blank,
        output seg, dp, an, frame
    );
endinterface

// File: rtl/seg_prescaler.sv
// Slot counter for the scan controller: counts 0..DIV-1 and wraps.
//   clk, reset : clock, synchronous active-high reset
//   clr        : holds the counter at 0
//   cnt        : current position inside the digit slot
//   blank_end  : high on the last cycle of the blanking window (never when BLANK=0)
//   tc         : terminal count, high when cnt = DIV-1
module seg_prescaler #(
    parameter int DIV   = 8,
    parameter int BLANK = 2,
    parameter int CW    = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          blank_end,
    output logic          tc
);
    localparam logic [CW-1:0] TC_VAL    = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic          HAS_BLANK = (BLANK > 0);

    assign tc        = (cnt == TC_VAL);
    assign blank_end = HAS_BLANK && (cnt == BLANK_END);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Steps one shared nibble decoder across DIGITS digits; each DIV-cycle slot
// begins with BLANK dark cycles to suppress ghosting.
//   clk, reset : clock, synchronous active-high reset
//   bus        : en/value/load/dp_mask/lz_blank in, seg/dp/an/frame out
//   dbg_state  : current scan FSM state (seg_pkg::state_e encoding)
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 500
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_ctrl_if.slave    bus,
    output logic [1:0]        dbg_state
);
    import seg_pkg::*;

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BLANK = ST_BLANK;
    localparam logic [1:0] S_DRIVE = ST_DRIVE;
    // A slot opens in BLANK unless the blanking window is empty.
    localparam logic [1:0] S_SLOT_START = (BLANK == 0) ? S_DRIVE : S_BLANK;

    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] PRE_TC    = CW'(DIV - 2);

    logic [1:0]            state;
    logic [IW-1:0]         idx;
    logic [CW-1:0]         cnt;
    logic                  blank_end;
    logic                  tc;
    logic [4*DIGITS-1:0]   pending;
    logic [4*DIGITS-1:0]   shown;
    logic                  last_digit;
    logic                  frame_edge;

    logic [DIGITS-1:0]     an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic                  frame_q;

    assign dbg_state  = state;
    assign last_digit = (idx == LAST_IDX);
    // Edge on which idx wraps back to digit 0.
    assign frame_edge = bus.en && (state == S_DRIVE) && tc && last_digit;

    seg_prescaler #(
        .DIV   (DIV),
        .BLANK (BLANK),
        .CW    (CW)
    ) u_presc (
        .clk       (clk),
        .reset     (reset),
        .clr       (!bus.en || (state == S_IDLE)),
        .cnt       (cnt),
        .blank_end (blank_end),
        .tc        (tc)
    );

    // Scan FSM and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else if (!bus.en) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_SLOT_START;
                    idx   <= '0;
                end
                S_BLANK: begin
                    if (blank_end) state <= S_DRIVE;
                end
                S_DRIVE: begin
                    if (tc) begin
                        state <= S_SLOT_START;
                        idx   <= last_digit ? '0 : idx + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Value capture. While scanning, shown only changes at the frame boundary
    // so a frame never mixes old and new digits; a load on that very edge
    // bypasses pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            shown   <= '0;
        end else begin
            if (bus.load) pending <= bus.value;
            if (state == S_IDLE) begin
                if (bus.load) shown <= bus.value;
            end else if (frame_edge) begin
                shown <= bus.load ? bus.value : pending;
            end
        end
    end

    // Select the active digit's nibble, dp bit and leading-zero flag.
    logic [3:0]        nib;
    logic              dp_sel;
    logic              hide;
    logic [DIGITS-1:0] lz_hide;
    logic              zero_run;
    logic [6:0]        glyph;

    always_comb begin
        // lz_hide[i]: nibbles DIGITS-1 down to i are all zero (digit 0 exempt).
        lz_hide  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (shown[4*i +: 4] == 4'h0);
            lz_hide[i] = zero_run;
        end

        nib    = '0;
        dp_sel = 1'b0;
        hide   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib    = shown[4*i +: 4];
                dp_sel = bus.dp_mask[i];
                hide   = lz_hide[i];
            end
        end

        glyph = (bus.lz_blank && hide) ? SEG_BLANK : hex_glyph(nib);
    end

    // Registered pin drivers. Gating on en makes the display go dark on the
    // first edge that sees en low, alongside the return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            if (bus.en && (state == S_DRIVE)) begin
                an_q  <= ~(DIGITS'(1) << idx);
                seg_q <= glyph;
                dp_q  <= ~dp_sel;
            end else begin
                an_q  <= '1;
                seg_q <= SEG_BLANK;
                dp_q  <= 1'b1;
            end
            // Look one cycle ahead so the pulse lines up with idx=DIGITS-1, cnt=DIV-1.
            frame_q <= bus.en && (state != S_IDLE) && last_digit && (cnt == PRE_TC);
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.frame = frame_q && bus.en;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    int vectors;
    int miscompares;
    int k;   // cycles since en rose from IDLE

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .BLANK  (BLANK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d got=%0h want=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, ".an"},    32'(bus.an),    32'hF);
        check({tag, ".seg"},   32'(bus.seg),   32'h7F);
        check({tag, ".dp"},    32'(bus.dp),    32'h1);
        check({tag, ".frame"}, 32'(bus.frame), 32'h0);
    endtask

    // One clock of scanning. g = {glyph3,glyph2,glyph1,glyph0} expected on
    // the digits; dpm = dp mask expected. Output at step k shows the scan
    // position of step k-1: k=1 is still dark, afterwards p cycles 0..31.
    task automatic step_check(input string tag, input logic [27:0] g, input logic [3:0] dpm);
        int         p;
        int         slot;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        logic       efr;
        tick();
        k++;
        ean  = 4'hF;
        eseg = 7'h7F;
        edp  = 1'b1;
        efr  = 1'b0;
        if (k >= 2) begin
            p    = (k - 2) % 32;
            slot = p / 8;
            if ((p % 8) >= BLANK) begin
                ean  = ~(4'b0001 << slot);
                eseg = g[slot*7 +: 7];
                edp  = ~dpm[slot];
            end
            efr = (p == 30);
        end
        check({tag, ".an"},    32'(bus.an),    32'(ean));
        check({tag, ".seg"},   32'(bus.seg),   32'(eseg));
        check({tag, ".dp"},    32'(bus.dp),    32'(edp));
        check({tag, ".frame"}, 32'(bus.frame), 32'(efr));
    endtask

    // Drop en, load a value while idle, raise en again.
    task automatic restart(input string tag, input logic [15:0] v);
        bus.en = 1'b0;
        tick();
        check_dark({tag, ".drop"});
        check({tag, ".state"}, 32'(dbg_state), 32'h0);
        bus.value = v;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        bus.en    = 1'b1;
        k = 0;
    endtask

    // hand-computed glyph sets {d3,d2,d1,d0}
    localparam logic [27:0] G_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] G_0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
    localparam logic [27:0] G_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] G_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] G_EF01 = {7'h06, 7'h0E, 7'h40, 7'h79};
    localparam logic [27:0] G_2222 = {7'h24, 7'h24, 7'h24, 7'h24};
    localparam logic [27:0] G_0808 = {7'h40, 7'h00, 7'h40, 7'h00};
    localparam logic [27:0] G_8888 = {7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [27:0] G_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};

    initial begin
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.dp_mask  = '0;
        bus.lz_blank = 1'b0;
        repeat (3) tick();
        check_dark("rst");
        check("rst.state", 32'(dbg_state), 32'h0);

        // idle with en low: dark, no frame pulses
        reset = 1'b0;
        for (int i = 0; i < 20; i++) check_dark("idle");

        // basic scan of 1234, two frames
        restart("r1234", 16'h1234);
        while (k < 65) step_check("s1234", G_1234, 4'h0);

        // leading-zero blanking
        bus.lz_blank = 1'b1;
        restart("r0050", 16'h0050);
        while (k < 33) step_check("lz0050", G_0050, 4'h0);
        restart("r0000", 16'h0000);
        while (k < 33) step_check("lz0000", G_0000, 4'h0);
        bus.lz_blank = 1'b0;

        // loads during scanning
        restart("rABCD", 16'hABCD);
        while (k < 10) step_check("ld.f0", G_ABCD, 4'h0);
        bus.value = 16'hEF01;
        bus.load  = 1'b1;
        step_check("ld.f0", G_ABCD, 4'h0);
        bus.load  = 1'b0;
        while (k < 33) step_check("ld.f0", G_ABCD, 4'h0);
        while (k < 40) step_check("ld.f1", G_EF01, 4'h0);
        bus.value = 16'h5555;
        bus.load  = 1'b1;
        step_check("ld.f1", G_EF01, 4'h0);
        bus.load  = 1'b0;
        while (k < 50) step_check("ld.f1", G_EF01, 4'h0);
        bus.value = 16'h2222;
        bus.load  = 1'b1;
        step_check("ld.f1", G_EF01, 4'h0);
        bus.load  = 1'b0;
        while (k < 65) step_check("ld.f1", G_EF01, 4'h0);
        while (k < 96) step_check("ld.f2", G_2222, 4'h0);
        // load sampled on the wrap edge goes straight to shown
        bus.value = 16'h0808;
        bus.load  = 1'b1;
        step_check("ld.f2", G_2222, 4'h0);
        bus.load  = 1'b0;
        while (k < 129) step_check("ld.f3", G_0808, 4'h0);

        // decimal point on digit 2 only
        bus.dp_mask = 4'b0100;
        restart("r8888", 16'h8888);
        while (k < 54) step_check("dp", G_8888, 4'b0100);
        // now idx=2, cnt=5: drop en
        bus.en = 1'b0;
        tick();
        check_dark("endrop");
        check("endrop.state", 32'(dbg_state), 32'h0);
        bus.en = 1'b1;
        k = 0;
        while (k < 5) step_check("reen", G_8888, 4'b0100);
        check("reen.an", 32'(bus.an), 32'hE);

        // reset mid-DRIVE
        reset = 1'b1;
        tick();
        check_dark("rstmid");
        check("rstmid.state", 32'(dbg_state), 32'h0);
        reset = 1'b0;
        bus.dp_mask = 4'h0;
        k = 0;
        while (k < 33) step_check("postrst", G_ZERO, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
